// File: rtl/motor_pwm_slave_if.sv
// Avalon-MM slave port bundle for motor_pwm_slave.
// Writes have zero wait states; reads stall one cycle on s_waitrequest.
interface motor_pwm_slave_if;
    logic        s_cs;
    logic [3:0]  s_address;
    logic        s_write;
    logic        s_read;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        s_waitrequest;

    modport master (
        output s_cs, s_address, s_write, s_read, s_writedata,
        input  s_readdata, s_waitrequest
    );

    modport slave (
        input  s_cs, s_address, s_write, s_read, s_writedata,
        output s_readdata, s_waitrequest
    );
endinterface

// File: rtl/motor_pwm_slave.sv
// Avalon-MM programmed PWM driver for one DRV8833-style H-bridge channel.
// Period/duty changes land on period boundaries; reversals coast for DEAD_CYCLES.
module motor_pwm_slave #(
    parameter int DEAD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    motor_pwm_slave_if.slave bus,
    output logic             motor_in1,
    output logic             motor_in2,
    output logic [1:0]       o_dbg_state
);
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_total;
    logic [31:0] r_high;
    logic [2:0]  r_ctrl;
    logic [31:0] r_tot_sh;
    logic [31:0] r_high_sh;
    logic        r_slow_sh;
    logic        r_dir;
    logic [31:0] r_cnt;
    logic [7:0]  r_dcnt;
    logic        r_rd_ack;
    logic [31:0] r_readdata;
    logic        r_in1;
    logic        r_in2;

    logic        w_wr;
    logic        w_rd;
    logic        w_go;
    logic        w_fwd;
    logic        w_tot_nz;
    logic        w_wrap;
    logic        w_dead_done;
    logic        w_enter_run;
    logic        w_load_sh;
    logic        w_pwm;
    logic        w_in1;
    logic        w_in2;

    // Handshake: a write completes on the edge where s_cs & s_write is high.
    // A read (s_cs & s_read without s_write) sees s_waitrequest high for one
    // cycle while s_readdata is captured, then completes with it low.
    assign w_wr = bus.s_cs & bus.s_write;
    assign w_rd = bus.s_cs & bus.s_read & ~bus.s_write;

    assign bus.s_waitrequest = w_rd & ~r_rd_ack;
    assign bus.s_readdata    = r_readdata;

    // CONTROL: bit0 go, bit1 forward, bit2 set selects slow (braking) decay.
    assign w_go        = r_ctrl[0];
    assign w_fwd       = r_ctrl[1];
    assign w_tot_nz    = (r_total != 32'd0);
    assign w_wrap      = (r_cnt == r_tot_sh - 32'd1);
    assign w_dead_done = (r_dcnt == DEAD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_total <= 32'd0;
            r_high  <= 32'd0;
            r_ctrl  <= 3'd0;
        end else if (w_wr) begin
            case (bus.s_address)
                4'd0:    r_total <= bus.s_writedata;
                4'd1:    r_high  <= bus.s_writedata;
                4'd2:    r_ctrl  <= bus.s_writedata[2:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ack   <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            r_rd_ack <= w_rd & ~r_rd_ack;
            if (w_rd && !r_rd_ack) begin
                case (bus.s_address)
                    4'd0:    r_readdata <= r_total;
                    4'd1:    r_readdata <= r_high;
                    4'd2:    r_readdata <= {29'd0, r_ctrl};
                    4'd3:    r_readdata <= r_cnt;
                    default: r_readdata <= 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go && w_tot_nz) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!w_go)                    w_next = ST_IDLE;
                else if (w_fwd != r_dir)      w_next = ST_DEAD;
                else if (w_wrap && !w_tot_nz) w_next = ST_IDLE;
            end
            ST_DEAD: begin
                if (!w_go)            w_next = ST_IDLE;
                else if (w_dead_done) w_next = w_tot_nz ? ST_RUN : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shadows track the live registers while idle, then only move at a
    // period boundary so a mid-period write never disturbs that period.
    assign w_enter_run = (w_next == ST_RUN) && (r_state != ST_RUN);
    assign w_load_sh   = (r_state == ST_IDLE) || w_enter_run ||
                         ((r_state == ST_RUN) && w_wrap);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tot_sh  <= 32'd0;
            r_high_sh <= 32'd0;
            r_slow_sh <= 1'b0;
            r_dir     <= 1'b0;
            r_cnt     <= 32'd0;
            r_dcnt    <= 8'd0;
        end else begin
            if (w_load_sh) begin
                r_tot_sh  <= r_total;
                r_high_sh <= r_high;
                r_slow_sh <= r_ctrl[2];
            end
            if (w_enter_run) r_dir <= w_fwd;
            if ((r_state == ST_RUN) && (w_next == ST_RUN) && !w_wrap)
                r_cnt <= r_cnt + 32'd1;
            else
                r_cnt <= 32'd0;
            if ((r_state == ST_DEAD) && (w_next == ST_DEAD))
                r_dcnt <= r_dcnt + 8'd1;
            else
                r_dcnt <= 8'd0;
        end
    end

    always_comb begin
        w_pwm = (r_cnt < r_high_sh);
        w_in1 = 1'b0;
        w_in2 = 1'b0;
        if (r_state == ST_RUN) begin
            case ({r_slow_sh, r_dir})
                2'b01: begin w_in1 = w_pwm;  w_in2 = 1'b0;   end
                2'b00: begin w_in1 = 1'b0;   w_in2 = w_pwm;  end
                2'b11: begin w_in1 = 1'b1;   w_in2 = ~w_pwm; end
                2'b10: begin w_in1 = ~w_pwm; w_in2 = 1'b1;   end
                default: begin w_in1 = 1'b0; w_in2 = 1'b0;   end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in1 <= 1'b0;
            r_in2 <= 1'b0;
        end else begin
            r_in1 <= w_in1;
            r_in2 <= w_in2;
        end
    end

    assign motor_in1   = r_in1;
    assign motor_in2   = r_in2;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_motor_pwm_slave.sv
// Self-checking bench for motor_pwm_slave: vector table, random runs against
// an arithmetic waveform model, and hand sequences for reads, reversal and reset.
module tb_motor_pwm_slave;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       motor_in1;
    logic       motor_in2;
    logic [1:0] dbg_state;

    motor_pwm_slave_if bus();

    motor_pwm_slave #(.DEAD_CYCLES(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .motor_in1   (motor_in1),
        .motor_in2   (motor_in2),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       mon_en  = 1'b0;
    logic [1:0] pin_log[$];
    logic [1:0] exp_q[$];

    // Pin monitor: one sample per cycle, 2 ns after the active edge.
    always @(posedge clk) begin
        #2;
        if (mon_en) pin_log.push_back({motor_in1, motor_in2});
    end

    typedef struct {
        string       name;
        int unsigned tot;
        int unsigned high;
        logic [2:0]  ctrl;
        int          n;
        logic [1:0]  exp_first;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.s_cs = 1'b1; bus.s_write = 1'b1; bus.s_read = 1'b0;
        bus.s_address = a; bus.s_writedata = d;
        @(negedge clk);
        bus.s_cs = 1'b0; bus.s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        bus.s_cs = 1'b1; bus.s_read = 1'b1; bus.s_write = 1'b0; bus.s_address = a;
        #1;
        while (bus.s_waitrequest && waits < 8) begin
            waits++;
            @(negedge clk);
            #1;
        end
        d = bus.s_readdata;
        @(negedge clk);
        bus.s_cs = 1'b0; bus.s_read = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int          w;
        bus_read(a, d, w);
        check({name, "_data"}, d, exp);
        check({name, "_waits"}, 32'(w), 32'd1);
    endtask

    // Expected pins {in1,in2} k cycles into a run with fixed settings.
    function automatic logic [1:0] model_pins(input int unsigned tot, input int unsigned high,
                                              input bit slow, input bit fwd, input int unsigned k);
        bit pwm;
        if (tot == 0) return 2'b00;
        pwm = (k % tot) < high;
        if (!slow) return fwd ? {pwm, 1'b0} : {1'b0, pwm};
        return fwd ? {1'b1, ~pwm} : {~pwm, 1'b1};
    endfunction

    task automatic wait_log(input int n);
        int guard = 0;
        while (pin_log.size() < n && guard < 50000) begin
            @(posedge clk);
            #3;
            guard++;
        end
    endtask

    task automatic compare_log(input string name);
        int         bad = 0;
        int         first = 0;
        logic [1:0] got_v = 2'b00;
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [1:0] g;
            g = (i < pin_log.size()) ? pin_log[i] : 2'bxx;
            if (g !== exp_q[i]) begin
                if (bad == 0) begin first = i; got_v = g; end
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d of %0d samples wrong, first at sample %0d got %b expected %b",
                     name, bad, exp_q.size(), first, got_v, exp_q[first]);
        end
    endtask

    // log[0] is the sample after edge T+1 (still coasting); log[1] is the first pwm level.
    task automatic start_run(input int unsigned tot, input int unsigned high, input logic [2:0] ctrl);
        mon_en = 1'b0;
        bus_write(4'd1, high);
        bus_write(4'd0, tot);
        pin_log.delete();
        exp_q.delete();
        bus_write(4'd2, 32'(ctrl));
        mon_en = 1'b1;
    endtask

    task automatic stop_run(input string name);
        mon_en = 1'b0;
        bus_write(4'd2, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check({name, "_stop_coast"}, 32'({motor_in1, motor_in2}), 32'd0);
    endtask

    task automatic run_vector(input vec_t v);
        start_run(v.tot, v.high, v.ctrl);
        exp_q.push_back(2'b00);
        for (int k = 0; k < v.n; k++)
            exp_q.push_back(model_pins(v.tot, v.high, v.ctrl[2], v.ctrl[1], k));
        wait_log(v.n + 1);
        compare_log(v.name);
        check({v.name, "_first"}, 32'((pin_log.size() > 1) ? pin_log[1] : 2'bxx), 32'(v.exp_first));
        stop_run(v.name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        vec_t        rv;
        logic [31:0] d;
        logic [3:0]  wpat;
        logic [31:0] d1;
        logic [31:0] d3;
        int          idx;
        int          n;

        bus.s_cs = 1'b0; bus.s_write = 1'b0; bus.s_read = 1'b0;
        bus.s_address = 4'd0; bus.s_writedata = 32'd0;

        vecs[0] = '{"fwd_fast_half", 7000, 3500, 3'b011, 14000, 2'b10};
        vecs[1] = '{"fwd_slow_2of4", 4, 2, 3'b111, 40, 2'b10};
        vecs[2] = '{"full_duty", 7000, 9000, 3'b011, 7010, 2'b10};
        vecs[3] = '{"zero_duty", 5, 0, 3'b011, 30, 2'b00};
        vecs[4] = '{"rev_fast", 10, 3, 3'b001, 40, 2'b01};
        vecs[5] = '{"rev_slow", 6, 4, 3'b101, 40, 2'b01};
        vecs[6] = '{"tot_one", 1, 1, 3'b011, 10, 2'b10};
        vecs[7] = '{"tot_zero_go", 0, 5, 3'b011, 20, 2'b00};
        vecs[8] = '{"rev_slow_zero", 3, 0, 3'b101, 12, 2'b11};

        // Clock/reset.
        repeat (3) @(negedge clk);
        #1;
        check("reset_pins", 32'({motor_in1, motor_in2}), 32'd0);
        check("reset_readdata", bus.s_readdata, 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_read("reset_total", 4'd0, 32'd0);
        check_read("reset_high", 4'd1, 32'd0);
        check_read("reset_ctrl", 4'd2, 32'd0);
        check_read("reset_count", 4'd3, 32'd0);

        // Register reads, ignored addresses and masking.
        bus_write(4'd0, 32'd7000);
        check_read("rd_total", 4'd0, 32'd7000);
        bus_write(4'd9, 32'd123);
        check_read("rd_addr9", 4'd9, 32'd0);
        check_read("rd_total_after_addr9", 4'd0, 32'd7000);
        bus_write(4'd2, 32'hFFFF_FFF8);
        check_read("rd_ctrl_masked", 4'd2, 32'd0);

        // Simultaneous read and write: write wins, no stall.
        @(negedge clk);
        bus.s_cs = 1'b1; bus.s_read = 1'b1; bus.s_write = 1'b1;
        bus.s_address = 4'd1; bus.s_writedata = 32'd77;
        #1;
        check("rw_no_wait", 32'(bus.s_waitrequest), 32'd0);
        @(negedge clk);
        bus.s_cs = 1'b0; bus.s_read = 1'b0; bus.s_write = 1'b0;
        check_read("rw_written", 4'd1, 32'd77);

        // Back-to-back reads with s_read held: stall, data, stall, data.
        @(negedge clk);
        bus.s_cs = 1'b1; bus.s_read = 1'b1; bus.s_address = 4'd0;
        #1; wpat[3] = bus.s_waitrequest;
        @(negedge clk); #1; wpat[2] = bus.s_waitrequest; d1 = bus.s_readdata;
        bus.s_address = 4'd1;
        @(negedge clk); #1; wpat[1] = bus.s_waitrequest;
        @(negedge clk); #1; wpat[0] = bus.s_waitrequest; d3 = bus.s_readdata;
        @(negedge clk);
        bus.s_cs = 1'b0; bus.s_read = 1'b0;
        check("b2b_wait_pattern", 32'(wpat), 32'b1010);
        check("b2b_data0", d1, 32'd7000);
        check("b2b_data1", d3, 32'd77);

        // Vector table.
        for (int i = 0; i < 9; i++) run_vector(vecs[i]);

        // TOTAL_DUR = 0 with go stays idle.
        bus_write(4'd0, 32'd0);
        bus_write(4'd2, 32'd3);
        repeat (5) @(negedge clk);
        check("tot_zero_state", 32'(dbg_state), 32'd0);
        check_read("tot_zero_count", 4'd3, 32'd0);
        bus_write(4'd2, 32'd0);

        // Randomized runs against the model.
        for (int r = 0; r < 8; r++) begin
            rv.name      = $sformatf("rand_%0d", r);
            rv.tot       = $urandom_range(1, 12);
            rv.high      = $urandom_range(0, 15);
            rv.ctrl      = 3'($urandom_range(0, 3) * 2 + 1);
            rv.n         = 3 * int'(rv.tot) + 5;
            rv.exp_first = model_pins(rv.tot, rv.high, rv.ctrl[2], rv.ctrl[1], 0);
            run_vector(rv);
        end

        // Mid-period HIGH_DUR write only affects the next period.
        start_run(7000, 3500, 3'b011);
        repeat (1000) @(negedge clk);
        bus_write(4'd1, 32'd1000);
        exp_q.push_back(2'b00);
        for (int k = 0; k < 14000; k++)
            exp_q.push_back(model_pins(7000, (k < 7000) ? 3500 : 1000, 1'b0, 1'b1, k));
        wait_log(14001);
        compare_log("mid_period_high");
        stop_run("mid_period_high");

        // Direction reversal: 16 coast samples, then fresh reverse period.
        start_run(10, 4, 3'b011);
        repeat (23) @(negedge clk);
        bus_write(4'd2, 32'd1);
        idx = pin_log.size();
        n = idx + 17 + 30;
        exp_q.push_back(2'b00);
        for (int i = 1; i < n; i++) begin
            if (i <= idx)           exp_q.push_back(model_pins(10, 4, 1'b0, 1'b1, i - 1));
            else if (i <= idx + 16) exp_q.push_back(2'b00);
            else                    exp_q.push_back(model_pins(10, 4, 1'b0, 1'b0, i - idx - 17));
        end
        wait_log(n);
        compare_log("dir_reverse");
        stop_run("dir_reverse");

        // Asynchronous reset mid-period.
        start_run(7000, 3500, 3'b011);
        repeat (500) @(negedge clk);
        check("pre_reset_in1", 32'(motor_in1), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_pins", 32'({motor_in1, motor_in2}), 32'd0);
        mon_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("post_reset_state", 32'(dbg_state), 32'd0);
        check_read("post_reset_total", 4'd0, 32'd0);
        check_read("post_reset_high", 4'd1, 32'd0);
        check_read("post_reset_ctrl", 4'd2, 32'd0);
        check_read("post_reset_count", 4'd3, 32'd0);
        check("post_reset_pins", 32'({motor_in1, motor_in2}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
